// File: rtl/aud_recorder.sv
// Codec ADC record path: captures 16-bit left-channel I2S samples in the BCLK
// domain and writes them to consecutive SRAM words starting at address 0.
module aud_recorder #(
    parameter logic [19:0] P_LAST_ADDR = 20'hFFFFF,
    parameter int          P_BITS      = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_pause,
    input  logic        i_stop,
    input  logic        i_lrc,
    input  logic        i_adc_dat,
    output logic [19:0] o_sram_addr,
    output logic [15:0] o_sram_data,
    output logic        o_sram_we_n,
    output logic [20:0] o_rec_len,
    output logic        o_busy,
    output logic        o_full
);

    // state   | meaning
    // S_IDLE  | not recording
    // S_WAIT  | armed, waiting for the left-channel LRC fall
    // S_SHIFT | shifting in one sample, MSB first
    // S_WRITE | single-cycle SRAM write of the captured sample
    // S_PAUSE | recording suspended, address and length held
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_PAUSE = 3'd4;

    localparam logic [4:0] L_LAST_BIT = 5'(P_BITS - 1);

    logic [2:0]        state_q, state_d;
    logic              lrc_q, lrc_d;
    logic [P_BITS-1:0] shift_q, shift_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [19:0]       addr_q, addr_d;
    logic [15:0]       data_q, data_d;
    logic [20:0]       rec_len_q, rec_len_d;
    logic              full_q, full_d;
    logic              lrc_fall;

    assign lrc_fall = lrc_q & ~i_lrc;

    always_comb begin
        state_d   = state_q;
        lrc_d     = i_lrc;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        rec_len_d = rec_len_q;
        full_d    = full_q;

        case (state_q)
            S_IDLE: begin
                if (i_start && !i_stop) begin
                    addr_d    = 20'd0;
                    rec_len_d = 21'd0;
                    full_d    = 1'b0;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_stop) begin
                    state_d = S_IDLE;
                end else if (i_pause) begin
                    state_d = S_PAUSE;
                end else if (lrc_fall) begin
                    bit_cnt_d = 5'd0;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (i_stop) begin
                    state_d = S_IDLE;
                end else if (i_pause) begin
                    state_d = S_PAUSE;
                end else begin
                    shift_d   = {shift_q[P_BITS-2:0], i_adc_dat};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == L_LAST_BIT) begin
                        data_d  = shift_d;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                // The write always completes, even when stop/pause arrive now.
                rec_len_d = 21'(addr_q) + 21'd1;
                if (addr_q == P_LAST_ADDR) begin
                    full_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    addr_d = addr_q + 20'd1;
                    if (i_stop) begin
                        state_d = S_IDLE;
                    end else if (i_pause) begin
                        state_d = S_PAUSE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_PAUSE: begin
                if (i_stop) begin
                    state_d = S_IDLE;
                end else if (i_start) begin
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            lrc_q     <= 1'b1;
            shift_q   <= '0;
            bit_cnt_q <= 5'd0;
            addr_q    <= 20'd0;
            data_q    <= 16'd0;
            rec_len_q <= 21'd0;
            full_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lrc_q     <= lrc_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            rec_len_q <= rec_len_d;
            full_q    <= full_d;
        end
    end

    // Decoded from state so an async reset releases the write strobe at once.
    assign o_sram_we_n = (state_q != S_WRITE);
    assign o_busy      = (state_q != S_IDLE);
    assign o_sram_addr = addr_q;
    assign o_sram_data = data_q;
    assign o_rec_len   = rec_len_q;
    assign o_full      = full_q;

endmodule

// File: tb/tb_aud_recorder.sv
// Scoreboard bench for aud_recorder: frames push expected SRAM writes,
// negedge monitors pop and compare address, data and write cycle.
`timescale 1ns/1ps
module tb_aud_recorder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, pause = 1'b0, stop = 1'b0;
    logic lrc = 1'b1, dat = 1'b0, sel = 1'b0;
    logic start_a, start_b;

    logic [19:0] addr_a, addr_b;
    logic [15:0] data_a, data_b;
    logic        we_a, we_b, busy_a, busy_b, full_a, full_b;
    logic [20:0] len_a, len_b;

    always #5 clk = ~clk;

    assign start_a = start & ~sel;
    assign start_b = start & sel;

    aud_recorder dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a), .i_pause(pause),
        .i_stop(stop), .i_lrc(lrc), .i_adc_dat(dat),
        .o_sram_addr(addr_a), .o_sram_data(data_a), .o_sram_we_n(we_a),
        .o_rec_len(len_a), .o_busy(busy_a), .o_full(full_a)
    );

    aud_recorder #(.P_LAST_ADDR(20'd3)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .i_pause(pause),
        .i_stop(stop), .i_lrc(lrc), .i_adc_dat(dat),
        .o_sram_addr(addr_b), .o_sram_data(data_b), .o_sram_we_n(we_b),
        .o_rec_len(len_b), .o_busy(busy_b), .o_full(full_b)
    );

    typedef struct packed {
        logic [19:0] addr;
        logic [15:0] data;
        logic [31:0] cyc;
    } wr_t;

    wr_t q_a[$];
    wr_t q_b[$];
    int n_vec = 0;
    int n_err = 0;
    logic [31:0] cyc = 0;
    logic prev_we_a = 1'b1, prev_we_b = 1'b1;

    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (we_a === 1'b0) begin
            chk("we_a_single_cycle", {31'd0, prev_we_a}, 32'd1);
            if (q_a.size() == 0) begin
                chk("write_a_unexpected_addr", {12'd0, addr_a}, 32'hFFFFFFFF);
            end else begin
                e = q_a.pop_front();
                chk("write_a_addr", {12'd0, addr_a}, {12'd0, e.addr});
                chk("write_a_data", {16'd0, data_a}, {16'd0, e.data});
                chk("write_a_cycle", cyc, e.cyc);
            end
        end
        prev_we_a = we_a;
    end

    always @(negedge clk) begin
        wr_t e;
        if (we_b === 1'b0) begin
            chk("we_b_single_cycle", {31'd0, prev_we_b}, 32'd1);
            if (q_b.size() == 0) begin
                chk("write_b_unexpected_addr", {12'd0, addr_b}, 32'hFFFFFFFF);
            end else begin
                e = q_b.pop_front();
                chk("write_b_addr", {12'd0, addr_b}, {12'd0, e.addr});
                chk("write_b_data", {16'd0, data_b}, {16'd0, e.data});
                chk("write_b_cycle", cyc, e.cyc);
            end
        end
        prev_we_b = we_b;
    end

    task automatic check_reset_a(input string tag);
        chk({tag, "_we_n"}, {31'd0, we_a}, 32'd1);
        chk({tag, "_addr"}, {12'd0, addr_a}, 32'd0);
        chk({tag, "_data"}, {16'd0, data_a}, 32'd0);
        chk({tag, "_len"}, {11'd0, len_a}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy_a}, 32'd0);
        chk({tag, "_full"}, {31'd0, full_a}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0; pause = 1'b0; stop = 1'b0; lrc = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // One 64-cycle LRC frame: left half (lrc=0) carries s in k=1..16.
    task automatic frame(input logic [15:0] s, input bit exp_wr, input logic [19:0] exp_addr,
                         input int ck, input bit c_stop, input bit c_pause, input bit c_rst);
        wr_t e;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (i == 0 && exp_wr) begin
                e.addr = exp_addr;
                e.data = s;
                e.cyc  = cyc + 32'd17;
                if (sel) q_b.push_back(e);
                else q_a.push_back(e);
            end
            lrc   = (i < 32) ? 1'b0 : 1'b1;
            dat   = (i >= 1 && i <= 16) ? s[16-i] : 1'($urandom);
            stop  = (i == ck) && c_stop;
            pause = (i == ck) && c_pause;
            if (i == ck && c_rst) begin
                #2 rst_n = 1'b0;
                #1 check_reset_a("t6_async_reset");
            end
        end
    endtask

    initial begin
        #12 check_reset_a("t0_reset");
        do_reset();

        // 1: single sample
        pulse_start();
        frame(16'hA5C3, 1, 20'd0, -1, 0, 0, 0);
        chk("t1_len", {11'd0, len_a}, 32'd1);
        chk("t1_addr", {12'd0, addr_a}, 32'd1);
        chk("t1_data", {16'd0, data_a}, 32'hA5C3);
        chk("t1_busy", {31'd0, busy_a}, 32'd1);

        // 2: three back-to-back frames
        do_reset();
        pulse_start();
        frame(16'h0001, 1, 20'd0, -1, 0, 0, 0);
        frame(16'h8000, 1, 20'd1, -1, 0, 0, 0);
        frame(16'hFFFF, 1, 20'd2, -1, 0, 0, 0);
        chk("t2_len", {11'd0, len_a}, 32'd3);
        chk("t2_busy", {31'd0, busy_a}, 32'd1);

        // 3: pause mid-shift discards the partial sample
        do_reset();
        pulse_start();
        frame(16'h1111, 1, 20'd0, -1, 0, 0, 0);
        frame(16'h2222, 0, 20'd0, 8, 0, 1, 0);
        for (int f = 0; f < 5; f++) frame(16'h3C3C, 0, 20'd0, -1, 0, 0, 0);
        chk("t3_paused_busy", {31'd0, busy_a}, 32'd1);
        chk("t3_paused_len", {11'd0, len_a}, 32'd1);
        pulse_start();
        frame(16'h1234, 1, 20'd1, -1, 0, 0, 0);
        chk("t3_len", {11'd0, len_a}, 32'd2);

        // 4: stop+pause during the write of address 4
        frame(16'h0F0F, 1, 20'd2, -1, 0, 0, 0);
        frame(16'h7FFF, 1, 20'd3, -1, 0, 0, 0);
        frame(16'hBEEF, 1, 20'd4, 17, 1, 1, 0);
        chk("t4_len", {11'd0, len_a}, 32'd5);
        chk("t4_busy", {31'd0, busy_a}, 32'd0);
        pulse_start();
        chk("t4_restart_addr", {12'd0, addr_a}, 32'd0);
        chk("t4_restart_len", {11'd0, len_a}, 32'd0);
        frame(16'h4321, 1, 20'd0, -1, 0, 0, 0);
        chk("t4_restart_len_after", {11'd0, len_a}, 32'd1);

        // 5: small-memory instance fills up at address 3
        do_reset();
        sel = 1'b1;
        pulse_start();
        frame(16'h1000, 1, 20'd0, -1, 0, 0, 0);
        frame(16'h2001, 1, 20'd1, -1, 0, 0, 0);
        frame(16'h3002, 1, 20'd2, -1, 0, 0, 0);
        frame(16'h4003, 1, 20'd3, -1, 0, 0, 0);
        frame(16'h5004, 0, 20'd0, -1, 0, 0, 0);
        frame(16'h6005, 0, 20'd0, -1, 0, 0, 0);
        chk("t5_full", {31'd0, full_b}, 32'd1);
        chk("t5_len", {11'd0, len_b}, 32'd4);
        chk("t5_busy", {31'd0, busy_b}, 32'd0);
        chk("t5_addr", {12'd0, addr_b}, 32'd3);
        pulse_start();
        chk("t5_full_cleared", {31'd0, full_b}, 32'd0);
        chk("t5_restart_busy", {31'd0, busy_b}, 32'd1);

        // 6: async reset while the write strobe is low
        do_reset();
        sel = 1'b0;
        pulse_start();
        frame(16'h5A5A, 1, 20'd0, 17, 0, 0, 1);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        chk("end_queue_a_empty", q_a.size(), 32'd0);
        chk("end_queue_b_empty", q_b.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
